obuf_readout_scheduler: RTL and testbench
=========================================

Name: obuf_readout_scheduler

Overview:
Owns the output-BRAM bank of the transpose-conv datapath between batches. On a batch-complete event it:
- holds the compute scheduler;
- waits for the pipeline to drain;
- streams a 6-word header, then every output BRAM word, onto one AXI-Stream master;
- zeroes the consumed BRAM region, then releases compute.

It sits between the transpose control top (batch_complete, ids) and the datapath external read/clear port. It replaces ad-hoc wrapper-driven read addressing.

Parameters:
DW, 16, data/stream width
NUM_BRAMS, 16, output BRAM count
O_ADDR_W, 9, output BRAM address width
DRAIN_CYCLES, 4, cycles waited after hold before first read (PE/psum pipeline flush)
FIFO_DEPTH, 4, readout skid FIFO depth (power of 2, ≥3)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
batch_complete  in  1  single-cycle pulse: batch results valid in output BRAMs
batch_id  in  3  batch id, sampled on accepted batch_complete
layer_id  in  2  layer id, sampled on accepted batch_complete
out_len  in  O_ADDR_W+1  words per BRAM to read/clear, sampled on accept; 0..2^O_ADDR_W
compute_hold  out  1  stalls scheduler; high from accept until done
ext_read_mode  out  1  datapath read/clear port owned by this block
ext_rd_bram  out  4  BRAM index of current read ($clog2(NUM_BRAMS))
ext_rd_addr  out  O_ADDR_W  read address, applied to all BRAMs
ext_rd_en  out  1  read strobe; data valid exactly 1 cycle later
ext_rd_data_flat  in  NUM_BRAMS*DW  read data, all BRAMs
ext_clr_we  out  NUM_BRAMS  per-BRAM write-zero enable
ext_clr_addr  out  O_ADDR_W  clear address
m_axis_tdata  out  DW  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  last beat of packet
busy  out  1  state != IDLE
done  out  1  1-cycle pulse on CLEAR→IDLE
overrun_err  out  1  sticky: batch_complete seen while busy

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, FIFO empty, all counters 0. All outputs 0, including compute_hold, ext_read_mode, tvalid and overrun_err.
- IDLE: batch_complete=1 → latch ids and out_len; compute_hold=1, ext_read_mode=1 next cycle; go to DRAIN.
- DRAIN: count DRAIN_CYCLES cycles, then go to HEADER.
- HEADER: 6 beats via the FIFO, in this order:
  - 0xC0DE
  - {8'b0, 3'b0, layer_id, batch_id}
  - out_len
  - NUM_BRAMS
  - (NUM_BRAMS*out_len)[15:0]
  - 0xFFFF
- HEADER exit: after the 6th beat enters the FIFO, go to READ. If out_len=0, skip READ and CLEAR; header word 5 carries tlast.
- READ order: bram 0..NUM_BRAMS-1 outer, addr 0..out_len-1 inner.
- Read issue rule: ext_rd_en=1 only when FIFO occupancy + in-flight (0/1) < FIFO_DEPTH. The next cycle pushes ext_rd_data_flat[ext_rd_bram*DW +: DW].
- Throughput: full rate (1 beat/cycle) when tready=1.
- tlast is set on the final data word (bram NUM_BRAMS-1, addr out_len-1) and is carried through the FIFO.
- READ → CLEAR once the last word is popped (tvalid&tready with tlast).
- CLEAR: ext_clr_we = all ones, ext_clr_addr = 0..out_len-1, one address per cycle (out_len cycles). Then done=1 for one cycle, compute_hold=0, ext_read_mode=0, state=IDLE.
- AXIS rules:
  - tdata/tlast stable while tvalid&!tready.
  - tvalid never drops without a handshake.
  - tvalid = FIFO non-empty (registered FIFO output).
- Simultaneous push/pop on a full FIFO is legal. Occupancy is unchanged, and the issue rule still holds.
- batch_complete while busy: ignored and overrun_err set. Cleared only by rst.
- batch_complete in the same cycle as done: ignored, overrun_err set (state is not yet IDLE).
- rst mid-packet: immediate return to reset values. A partial packet is abandoned with no tlast, and the BRAM is not cleared.
- Width: out_len=2^O_ADDR_W is legal. Address counters wrap only at the terminal count compare, never by overflow.

Decomposition:
- Package obuf_rd_pkg holds:
  - state encoding: IDLE, DRAIN, HEADER, READ, CLEAR;
  - HDR_MAGIC=16'hC0DE, HDR_TRAILER=16'hFFFF, HDR_WORDS=6.
- Sub-module axis_skid_fifo: parameters DW+1 bits wide, FIFO_DEPTH deep. It provides push/pop, count, full/empty and registered output, and holds data+tlast.

Test Plan:
- out_len=4, tready=1: 70 beats. Header is C0DE, 0005 (layer 0, batch 5), 0004, 0010, 0040, FFFF, then 64 data words in bram-major order. tlast only on beat 70, then 4 clear cycles with ext_clr_we=FFFF, then done, compute_hold low.
- Same config, tready toggling 1-0 with random stalls of up to 5 cycles: identical beat sequence, tdata stable during stalls, FIFO never overflows, ext_rd_en suppressed while occupancy+inflight=4.
- out_len=0: exactly 6 header beats, tlast on 0xFFFF, no ext_rd_en, no clear cycles, done 7+DRAIN_CYCLES cycles after the accept at the latest with tready=1.
- Second batch_complete during READ: sequence unaffected, overrun_err=1 and stays 1 after done.
- rst asserted on data beat 20: next cycle all outputs 0, state IDLE. A new batch_complete then produces a full correct packet.
- out_len=512 (O_ADDR_W=9): 8192 data words, last address 511 on bram 15, header word 4 = 0x2000, 512 clear cycles.

Source files
------------

// File: rtl/obuf_rd_pkg.sv
// Shared state encoding, header constants and header word builder for the
// output-BRAM readout scheduler.
package obuf_rd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      HEADER,
      READ,
      CLEAR
   } rd_state_t;

   localparam logic [15:0] HDR_MAGIC   = 16'hC0DE;
   localparam logic [15:0] HDR_TRAILER = 16'hFFFF;
   localparam int          HDR_WORDS   = 6;

   // Word 4 is the total data word count, deliberately truncated to 16 bits.
   function automatic logic [15:0] hdr_word(
      input logic [2:0]  idx,
      input logic [1:0]  layer,
      input logic [2:0]  batch,
      input logic [15:0] len16,
      input logic [15:0] nbrams16
   );
      logic [15:0] word;
      case (idx)
         3'd0:    word = HDR_MAGIC;
         3'd1:    word = {8'b0, 3'b0, layer, batch};
         3'd2:    word = len16;
         3'd3:    word = nbrams16;
         3'd4:    word = len16 * nbrams16;
         default: word = HDR_TRAILER;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/axis_skid_fifo.sv
// Small power-of-two FIFO holding {tlast, tdata}; head word is presented
// straight from the storage registers and reads as zero while empty.
module axis_skid_fifo #(
   parameter int W     = 17,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             head_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign count   = count_reg;
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is accepted only when a pop frees the slot.
   assign do_push = push && (!full || do_pop);
   assign head_data = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/obuf_readout_scheduler.sv
// Batch-boundary owner of the output BRAM bank: holds compute, drains, streams
// a header plus all BRAM words on AXI-Stream, zeroes the region, releases.
module obuf_readout_scheduler
   import obuf_rd_pkg::*;
#(
   parameter int DW           = 16,
   parameter int NUM_BRAMS    = 16,
   parameter int O_ADDR_W     = 9,
   parameter int DRAIN_CYCLES = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          batch_complete,
   input  logic [2:0]                    batch_id,
   input  logic [1:0]                    layer_id,
   input  logic [O_ADDR_W:0]             out_len,
   output logic                          compute_hold,
   output logic                          ext_read_mode,
   output logic [$clog2(NUM_BRAMS)-1:0]  ext_rd_bram,
   output logic [O_ADDR_W-1:0]           ext_rd_addr,
   output logic                          ext_rd_en,
   input  logic [NUM_BRAMS*DW-1:0]       ext_rd_data_flat,
   output logic [NUM_BRAMS-1:0]          ext_clr_we,
   output logic [O_ADDR_W-1:0]           ext_clr_addr,
   output logic [DW-1:0]                 m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          busy,
   output logic                          done,
   output logic                          overrun_err
);
   localparam int BW  = $clog2(NUM_BRAMS);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   localparam int DCW = $clog2(DRAIN_CYCLES + 1);

   rd_state_t state_reg, state_next;

   logic [2:0]          batch_reg;
   logic [1:0]          layer_reg;
   logic [O_ADDR_W:0]   len_reg;
   logic [DCW-1:0]      drain_cnt_reg;
   logic [2:0]          hdr_idx_reg;
   logic [O_ADDR_W-1:0] rd_addr_reg;
   logic [BW-1:0]       rd_bram_reg;
   logic                issue_done_reg;
   logic                inflight_reg;
   logic                inflight_last_reg;
   logic [BW-1:0]       inflight_bram_reg;
   logic [O_ADDR_W-1:0] clr_addr_reg;
   logic                overrun_reg;

   logic [O_ADDR_W-1:0] last_addr;
   logic                len_zero;
   logic                accept;
   logic                drain_last;
   logic                hdr_push;
   logic                hdr_last;
   logic                addr_last;
   logic                bram_last;
   logic                clr_last;
   logic                room;
   logic [CW:0]         occupancy;
   logic                rd_en;
   logic                pop;
   logic                pop_last;

   logic                fifo_push;
   logic [DW:0]         fifo_push_data;
   logic [DW:0]         fifo_head;
   logic                fifo_empty;
   logic                fifo_full;
   logic [CW-1:0]       fifo_count;
   logic [DW-1:0]       hdr_data;

   // For out_len = 2^O_ADDR_W the low bits are zero and this wraps to all ones.
   assign last_addr  = len_reg[O_ADDR_W-1:0] - 1'b1;
   assign len_zero   = (len_reg == '0);
   assign accept     = (state_reg == IDLE) && batch_complete;
   assign drain_last = (drain_cnt_reg == DCW'(DRAIN_CYCLES - 1));
   assign hdr_push   = (state_reg == HEADER) && !fifo_full;
   assign hdr_last   = (hdr_idx_reg == 3'(HDR_WORDS - 1));
   assign addr_last  = (rd_addr_reg == last_addr);
   assign bram_last  = (rd_bram_reg == BW'(NUM_BRAMS - 1));
   assign clr_last   = (clr_addr_reg == last_addr);

   // Count the read in flight so its data always has a slot next cycle.
   assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_reg};
   assign room      = (occupancy < (CW+1)'(FIFO_DEPTH));
   assign rd_en     = (state_reg == READ) && !len_zero && !issue_done_reg && room;

   assign pop      = m_axis_tvalid && m_axis_tready;
   assign pop_last = pop && m_axis_tlast;

   assign hdr_data = DW'(hdr_word(hdr_idx_reg, layer_reg, batch_reg,
                                  16'(len_reg), 16'(NUM_BRAMS)));

   assign fifo_push      = hdr_push || inflight_reg;
   assign fifo_push_data = hdr_push
                         ? {hdr_last && len_zero, hdr_data}
                         : {inflight_last_reg, ext_rd_data_flat[inflight_bram_reg*DW +: DW]};

   axis_skid_fifo #(
      .W     (DW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (m_axis_tready),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_head[DW-1:0];
   assign m_axis_tlast  = fifo_head[DW];

   assign busy          = (state_reg != IDLE);
   assign compute_hold  = busy;
   assign ext_read_mode = busy;
   assign ext_rd_en     = rd_en;
   assign ext_rd_bram   = rd_bram_reg;
   assign ext_rd_addr   = rd_addr_reg;
   assign ext_clr_addr  = clr_addr_reg;
   assign overrun_err   = overrun_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A zero-length batch has its tlast on the header trailer, so READ just
   // waits for that beat and finishes without a clear pass.
   always_comb begin
      state_next = state_reg;
      done       = 1'b0;
      ext_clr_we = '0;
      case (state_reg)
         IDLE:    if (batch_complete) state_next = DRAIN;
         DRAIN:   if (drain_last) state_next = HEADER;
         HEADER:  if (hdr_push && hdr_last) state_next = READ;
         READ: begin
            if (pop_last) begin
               if (len_zero) begin
                  state_next = IDLE;
                  done       = 1'b1;
               end else begin
                  state_next = CLEAR;
               end
            end
         end
         CLEAR: begin
            ext_clr_we = '1;
            if (clr_last) begin
               state_next = IDLE;
               done       = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         batch_reg         <= '0;
         layer_reg         <= '0;
         len_reg           <= '0;
         drain_cnt_reg     <= '0;
         hdr_idx_reg       <= '0;
         rd_addr_reg       <= '0;
         rd_bram_reg       <= '0;
         issue_done_reg    <= 1'b0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
         inflight_bram_reg <= '0;
         clr_addr_reg      <= '0;
         overrun_reg       <= 1'b0;
      end else begin
         if (accept) begin
            batch_reg <= batch_id;
            layer_reg <= layer_id;
            len_reg   <= out_len;
         end
         if (batch_complete && state_reg != IDLE) begin
            overrun_reg <= 1'b1;
         end
         drain_cnt_reg <= (state_reg == DRAIN && !drain_last) ? drain_cnt_reg + 1'b1 : '0;
         if (hdr_push) begin
            hdr_idx_reg <= hdr_last ? 3'd0 : hdr_idx_reg + 3'd1;
         end

         inflight_reg      <= rd_en;
         inflight_last_reg <= rd_en && addr_last && bram_last;
         inflight_bram_reg <= rd_bram_reg;

         // Counters wrap on terminal-count compare only.
         if (rd_en) begin
            if (addr_last) begin
               rd_addr_reg <= '0;
               if (bram_last) begin
                  rd_bram_reg    <= '0;
                  issue_done_reg <= 1'b1;
               end else begin
                  rd_bram_reg <= rd_bram_reg + 1'b1;
               end
            end else begin
               rd_addr_reg <= rd_addr_reg + 1'b1;
            end
         end
         if (state_reg == IDLE) begin
            issue_done_reg <= 1'b0;
         end
         if (state_reg == CLEAR) begin
            clr_addr_reg <= clr_last ? '0 : clr_addr_reg + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_obuf_readout_scheduler.sv
// Bench for obuf_readout_scheduler: BRAM model with random contents, stream
// monitor, and a packet-level reference built from the header/readout rules.
module tb_obuf_readout_scheduler;
   localparam int DW    = 16;
   localparam int NB    = 16;
   localparam int AW    = 9;
   localparam int DRAIN = 4;
   localparam int DEPTH = 4;
   localparam int WORDS = 1 << AW;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                batch_complete = 1'b0;
   logic [2:0]          batch_id = '0;
   logic [1:0]          layer_id = '0;
   logic [AW:0]         out_len = '0;
   logic                compute_hold, ext_read_mode, ext_rd_en;
   logic [3:0]          ext_rd_bram;
   logic [AW-1:0]       ext_rd_addr, ext_clr_addr;
   logic [NB*DW-1:0]    ext_rd_data_flat = '0;
   logic [NB-1:0]       ext_clr_we;
   logic [DW-1:0]       m_axis_tdata;
   logic                m_axis_tvalid, m_axis_tlast, busy, done, overrun_err;
   logic                m_axis_tready = 1'b1;

   obuf_readout_scheduler #(
      .DW(DW), .NUM_BRAMS(NB), .O_ADDR_W(AW), .DRAIN_CYCLES(DRAIN), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .batch_complete(batch_complete), .batch_id(batch_id),
      .layer_id(layer_id), .out_len(out_len), .compute_hold(compute_hold),
      .ext_read_mode(ext_read_mode), .ext_rd_bram(ext_rd_bram), .ext_rd_addr(ext_rd_addr),
      .ext_rd_en(ext_rd_en), .ext_rd_data_flat(ext_rd_data_flat), .ext_clr_we(ext_clr_we),
      .ext_clr_addr(ext_clr_addr), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done),
      .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // BRAM bank model: registered read, per-BRAM write-zero, bulk random fill.
   logic [DW-1:0] mem [NB][WORDS];
   logic [DW-1:0] snap [NB][WORDS];
   logic          fill_req = 1'b0;
   always @(posedge clk) begin
      if (fill_req) begin
         for (int b = 0; b < NB; b++)
            for (int a = 0; a < WORDS; a++)
               mem[b][a] <= 16'($urandom_range(1, 65535));
      end else begin
         if (ext_rd_en)
            for (int b = 0; b < NB; b++)
               ext_rd_data_flat[b*DW +: DW] <= mem[b][ext_rd_addr];
         for (int b = 0; b < NB; b++)
            if (ext_clr_we[b]) mem[b][ext_clr_addr] <= '0;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Sink back-pressure: ready, or a random stall of 1..5 cycles.
   logic stall_en = 1'b0;
   int   stall_left = 0;
   always @(posedge clk) begin
      #2;
      if (!stall_en) begin
         m_axis_tready = 1'b1;
         stall_left = 0;
      end else if (stall_left > 0) begin
         m_axis_tready = 1'b0;
         stall_left--;
      end else begin
         m_axis_tready = 1'b1;
         if ($urandom_range(0, 1) == 1) stall_left = $urandom_range(1, 5);
      end
   end

   // Observation only; tests compare these records against the reference.
   logic          mon_clear = 1'b0;
   logic [DW:0]   obs_q[$];
   int            reads_issued, issue_viol, stall_viol, clr_cnt, clr_bad, done_cnt, done_cyc;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic          prev_last;
   always @(negedge clk) begin
      if (mon_clear) begin
         obs_q.delete();
         reads_issued = 0; issue_viol = 0; stall_viol = 0;
         clr_cnt = 0; clr_bad = 0; done_cnt = 0; done_cyc = 0;
         prev_stall = 1'b0;
      end else if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data
                            || m_axis_tlast !== prev_last))
            stall_viol++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
         if (ext_rd_en) begin
            if (HDRS + reads_issued - obs_q.size() >= DEPTH) issue_viol++;
            reads_issued++;
         end
         if (m_axis_tvalid && m_axis_tready) obs_q.push_back({m_axis_tlast, m_axis_tdata});
         if (ext_clr_we != '0) begin
            if (ext_clr_we !== '1 || ext_clr_addr !== 9'(clr_cnt)) clr_bad++;
            clr_cnt++;
         end
         if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
         end
      end
   end
   localparam int HDRS = 6;

   logic [DW:0] exp_q[$];
   int          accept_cyc;

   function automatic int mem_diff(input int cleared_len);
      int bad = 0;
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < WORDS; a++)
            if (mem[b][a] !== ((a < cleared_len) ? 16'h0000 : snap[b][a])) bad++;
      return bad;
   endfunction

   task automatic do_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic start_batch(input int len, input logic [2:0] bid, input logic [1:0] lid);
      fill_req = 1'b1;
      @(posedge clk); #2;
      fill_req = 1'b0;
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < WORDS; a++)
            snap[b][a] = mem[b][a];
      exp_q.delete();
      exp_q.push_back({1'b0, 16'hC0DE});
      exp_q.push_back({1'b0, 8'h00, 3'b000, lid, bid});
      exp_q.push_back({1'b0, 16'(len)});
      exp_q.push_back({1'b0, 16'(NB)});
      exp_q.push_back({1'b0, 16'(NB * len)});
      exp_q.push_back({len == 0, 16'hFFFF});
      for (int b = 0; b < NB; b++)
         for (int a = 0; a < len; a++)
            exp_q.push_back({(b == NB - 1) && (a == len - 1), snap[b][a]});
      mon_clear = 1'b1;
      @(negedge clk); #1;
      mon_clear = 1'b0;
      @(posedge clk); #2;
      batch_complete = 1'b1;
      batch_id = bid;
      layer_id = lid;
      out_len = (AW+1)'(len);
      accept_cyc = cyc;
      @(posedge clk); #2;
      batch_complete = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
      vectors++;
      if (done_cnt == 0) begin
         $display("FAIL %s done_timeout: got no done within %0d cycles, required done", name, budget);
         miscompares++;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_beats(input int n, input string name);
      for (int i = 0; i < 5000 && obs_q.size() < n; i++) @(negedge clk);
      vectors++;
      if (obs_q.size() < n) begin
         $display("FAIL %s beat_timeout: got %0d beats, required %0d", name, obs_q.size(), n);
         miscompares++;
      end
   endtask

   task automatic check_packet(input int len, input string name);
      int n;
      vectors++;
      if (obs_q.size() !== exp_q.size()) begin
         $display("FAIL %s beat_count: got %0d, expected %0d", name, obs_q.size(), exp_q.size());
         miscompares++;
      end
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            $display("FAIL %s beat%0d {tlast,tdata}: got %h, expected %h", name, i, obs_q[i], exp_q[i]);
            miscompares++;
         end
      end
      vectors++;
      if (stall_viol !== 0) begin
         $display("FAIL %s axis_stability: got %0d violations, expected 0", name, stall_viol);
         miscompares++;
      end
      vectors++;
      if (issue_viol !== 0) begin
         $display("FAIL %s issue_rule: got %0d reads with full buffer, expected 0", name, issue_viol);
         miscompares++;
      end
      vectors++;
      if (clr_cnt !== len || clr_bad !== 0) begin
         $display("FAIL %s clear_cycles: got %0d (%0d bad), expected %0d (0 bad)", name, clr_cnt, clr_bad, len);
         miscompares++;
      end
      vectors++;
      if (done_cnt !== 1) begin
         $display("FAIL %s done_pulses: got %0d, expected 1", name, done_cnt);
         miscompares++;
      end
      vectors++;
      if ({compute_hold, ext_read_mode, busy} !== 3'b000) begin
         $display("FAIL %s release: got hold/mode/busy %b, expected 000", name, {compute_hold, ext_read_mode, busy});
         miscompares++;
      end
      vectors++;
      if (mem_diff(len) !== 0) begin
         $display("FAIL %s bram_contents: got %0d wrong words, expected 0", name, mem_diff(len));
         miscompares++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      vectors++;
      if ({compute_hold, ext_read_mode, ext_rd_bram, ext_rd_addr, ext_rd_en, ext_clr_we, ext_clr_addr,
           m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, done, overrun_err} !== '0) begin
         $display("FAIL reset outputs: got hold=%b valid=%b busy=%b ovr=%b clr_we=%h, expected all 0",
                  compute_hold, m_axis_tvalid, busy, overrun_err, ext_clr_we);
         miscompares++;
      end
   endtask

   task automatic test_basic();
      start_batch(4, 3'd5, 2'd0);
      wait_done(400, "basic");
      check_packet(4, "basic");
   endtask

   task automatic test_stall();
      stall_en = 1'b1;
      start_batch(4, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      wait_done(3000, "stall");
      stall_en = 1'b0;
      check_packet(4, "stall");
   endtask

   task automatic test_zero_len();
      start_batch(0, 3'd3, 2'd2);
      wait_done(200, "zero_len");
      check_packet(0, "zero_len");
      vectors++;
      if (reads_issued !== 0) begin
         $display("FAIL zero_len reads: got %0d ext_rd_en cycles, expected 0", reads_issued);
         miscompares++;
      end
      vectors++;
      if (done_cyc - accept_cyc > 7 + DRAIN) begin
         $display("FAIL zero_len done_latency: got %0d cycles, expected <= %0d", done_cyc - accept_cyc, 7 + DRAIN);
         miscompares++;
      end
   endtask

   task automatic test_overrun();
      int len;
      len = $urandom_range(2, 8);
      vectors++;
      if (overrun_err !== 1'b0) begin
         $display("FAIL overrun initial: got %b, expected 0", overrun_err);
         miscompares++;
      end
      start_batch(len, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      wait_beats(HDRS + 4, "overrun");
      @(posedge clk); #2 batch_complete = 1'b1;
      @(posedge clk); #2 batch_complete = 1'b0;
      wait_done(500, "overrun");
      check_packet(len, "overrun");
      repeat (5) @(negedge clk);
      vectors++;
      if ({overrun_err, busy} !== 2'b10) begin
         $display("FAIL overrun sticky: got ovr=%b busy=%b, expected ovr=1 busy=0", overrun_err, busy);
         miscompares++;
      end
   endtask

   task automatic test_done_collision();
      bit seen;
      do_reset();
      start_batch(3, 3'd1, 2'd1);
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      #1 batch_complete = 1'b1;
      @(posedge clk); #2 batch_complete = 1'b0;
      repeat (4) @(negedge clk);
      check_packet(3, "done_collision");
      vectors++;
      if ({overrun_err, busy} !== 2'b10) begin
         $display("FAIL done_collision state: got ovr=%b busy=%b, expected ovr=1 busy=0", overrun_err, busy);
         miscompares++;
      end
   endtask

   task automatic test_reset_mid();
      int lasts;
      do_reset();
      start_batch(4, 3'd6, 2'd3);
      wait_beats(HDRS + 20, "reset_mid");
      #1 rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({compute_hold, ext_read_mode, ext_rd_en, ext_clr_we, m_axis_tdata, m_axis_tvalid,
           m_axis_tlast, busy, done, overrun_err, ext_rd_bram, ext_rd_addr} !== '0) begin
         $display("FAIL reset_mid outputs: got hold=%b valid=%b rd_en=%b busy=%b, expected all 0",
                  compute_hold, m_axis_tvalid, ext_rd_en, busy);
         miscompares++;
      end
      lasts = 0;
      foreach (obs_q[i]) if (obs_q[i][DW]) lasts++;
      vectors++;
      if (lasts !== 0 || clr_cnt !== 0 || mem_diff(0) !== 0) begin
         $display("FAIL reset_mid abandon: got tlast=%0d clears=%0d changed=%0d, expected 0 0 0",
                  lasts, clr_cnt, mem_diff(0));
         miscompares++;
      end
      #2 rst = 1'b0;
      start_batch(4, 3'd2, 2'd1);
      wait_done(400, "after_reset");
      check_packet(4, "after_reset");
   endtask

   task automatic test_max_len();
      start_batch(WORDS, 3'd7, 2'd3);
      wait_done(20000, "max_len");
      check_packet(WORDS, "max_len");
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_len();
      test_overrun();
      test_done_collision();
      test_reset_mid();
      test_max_len();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
